// File: rtl/set_assoc_cache.sv
// set_assoc_cache: N-way set-associative, write-back, write-allocate cache
// between the core load/store path and a line-wide memory.
//
// Optional build macro: CACHE_PERF_COUNTERS_EN adds the hit_count,
// miss_count and wb_count outputs (32-bit, wrapping).
//
// Ports:
//   clk, reset (asynchronous, active-high)
//   req_valid/req_ready/req_write/req_byte/req_addr/req_wdata : core request
//   resp_valid/resp_rdata/resp_hit : one-cycle response pulse
//   mem_req_valid/mem_req_write/mem_addr/mem_wdata : line request to memory
//   mem_rdata/mem_ack : refill line and one-cycle completion from memory
module set_assoc_cache #(
  parameter int ADDRESS_WIDTH  = 32,
  parameter int WORD_WIDTH     = 32,
  parameter int WORDS_PER_LINE = 4,
  parameter int NUM_SETS       = 4,
  parameter int NUM_WAYS       = 4
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                req_valid,
  output logic                                req_ready,
  input  logic                                req_write,
  input  logic                                req_byte,
  input  logic [ADDRESS_WIDTH-1:0]            req_addr,
  input  logic [WORD_WIDTH-1:0]               req_wdata,
  output logic                                resp_valid,
  output logic [WORD_WIDTH-1:0]               resp_rdata,
  output logic                                resp_hit,
  output logic                                mem_req_valid,
  output logic                                mem_req_write,
  output logic [ADDRESS_WIDTH-1:0]            mem_addr,
  output logic [WORD_WIDTH*WORDS_PER_LINE-1:0] mem_wdata,
  input  logic [WORD_WIDTH*WORDS_PER_LINE-1:0] mem_rdata,
  input  logic                                mem_ack
`ifdef CACHE_PERF_COUNTERS_EN
  ,
  output logic [31:0]                         hit_count,
  output logic [31:0]                         miss_count,
  output logic [31:0]                         wb_count
`endif
);

  localparam int LINE_BITS      = WORD_WIDTH * WORDS_PER_LINE;
  localparam int BYTES_PER_WORD = WORD_WIDTH / 8;
  localparam int OFFSET_W       = $clog2(WORDS_PER_LINE * BYTES_PER_WORD);
  localparam int BYTE_W         = $clog2(BYTES_PER_WORD);
  localparam int WIDX_W         = $clog2(WORDS_PER_LINE);
  localparam int INDEX_W        = $clog2(NUM_SETS);
  localparam int SET_W          = (INDEX_W > 0) ? INDEX_W : 1;
  localparam int TAG_W          = ADDRESS_WIDTH - INDEX_W - OFFSET_W;
  localparam int WAY_W          = $clog2(NUM_WAYS);

  typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, REFILL, RESPOND} state_t;

  state_t                   state_q;
  logic                     req_write_q, req_byte_q, missed_q;
  logic [ADDRESS_WIDTH-1:0] req_addr_q;
  logic [WORD_WIDTH-1:0]    req_wdata_q;
  logic [WAY_W-1:0]         victim_q;
  logic [NUM_WAYS-1:0]      valid_q [NUM_SETS];
  logic [NUM_WAYS-1:0]      dirty_q [NUM_SETS];
  logic [WAY_W-1:0]         age_q   [NUM_SETS][NUM_WAYS];
  logic [TAG_W-1:0]         tag_q   [NUM_SETS][NUM_WAYS];
  logic [LINE_BITS-1:0]     data_q  [NUM_SETS][NUM_WAYS];

  logic                     req_ready_q, resp_valid_q, resp_hit_q;
  logic [WORD_WIDTH-1:0]    resp_rdata_q;
  logic                     mem_req_valid_q, mem_req_write_q;
  logic [ADDRESS_WIDTH-1:0] mem_addr_q;
  logic [LINE_BITS-1:0]     mem_wdata_q;
`ifdef CACHE_PERF_COUNTERS_EN
  logic [31:0]              hit_count_q, miss_count_q, wb_count_q;
`endif

  // Lookup datapath, all derived from the latched request.
  logic [TAG_W-1:0]         req_tag_d;
  logic [SET_W-1:0]         set_d;
  logic [31:0]              word_base_d;
  logic [ADDRESS_WIDTH-1:0] lane_shift_d;
  logic [NUM_WAYS-1:0]      match_d;
  logic                     hit_d;
  logic [WAY_W-1:0]         hit_way_d, hit_age_d, victim_d, victim_inv_d, victim_lru_d;
  logic [WAY_W-1:0]         new_age_d [NUM_WAYS];
  logic [WORD_WIDTH-1:0]    cur_word_d, load_d, byte_mask_d, store_word_d;
  logic [7:0]               byte_d;

  // Memory-side line address built from a tag and set index.
  function automatic logic [ADDRESS_WIDTH-1:0] line_addr(input logic [TAG_W-1:0] tag,
                                                         input logic [SET_W-1:0] set);
    line_addr = (ADDRESS_WIDTH'(tag) << (INDEX_W + OFFSET_W)) |
                (ADDRESS_WIDTH'(set) << OFFSET_W);
  endfunction

  // Tag compare, victim choice, LRU ages and load/store word formatting.
  always_comb begin
    req_tag_d    = req_addr_q[ADDRESS_WIDTH-1 -: TAG_W];
    set_d        = SET_W'((req_addr_q >> OFFSET_W) & ADDRESS_WIDTH'(NUM_SETS - 1));
    word_base_d  = 32'(WIDX_W'(req_addr_q >> BYTE_W)) * 32'(WORD_WIDTH);
    lane_shift_d = (req_addr_q & ADDRESS_WIDTH'(BYTES_PER_WORD - 1)) << 3;
    hit_way_d    = '0;
    victim_inv_d = '0;
    victim_lru_d = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      match_d[w] = valid_q[set_d][w] && (tag_q[set_d][w] == req_tag_d);
    end
    hit_d = |match_d;
    // Descending scan so the lowest-index candidate wins.
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      hit_way_d    = match_d[w] ? WAY_W'(w) : hit_way_d;
      victim_inv_d = valid_q[set_d][w] ? victim_inv_d : WAY_W'(w);
      victim_lru_d = (age_q[set_d][w] == '0) ? WAY_W'(w) : victim_lru_d;
    end
    victim_d  = (&valid_q[set_d]) ? victim_lru_d : victim_inv_d;
    hit_age_d = age_q[set_d][hit_way_d];
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (WAY_W'(w) == hit_way_d) begin
        new_age_d[w] = WAY_W'(NUM_WAYS - 1);
      end else if (age_q[set_d][w] > hit_age_d) begin
        new_age_d[w] = age_q[set_d][w] - WAY_W'(1);
      end else begin
        new_age_d[w] = age_q[set_d][w];
      end
    end
    cur_word_d   = data_q[set_d][hit_way_d][word_base_d +: WORD_WIDTH];
    byte_d       = 8'(cur_word_d >> lane_shift_d);
    load_d       = req_byte_q ? WORD_WIDTH'(byte_d) : cur_word_d;
    byte_mask_d  = WORD_WIDTH'(8'hFF) << lane_shift_d;
    store_word_d = req_byte_q ? ((cur_word_d & ~byte_mask_d) |
                                 (WORD_WIDTH'(req_wdata_q[7:0]) << lane_shift_d))
                              : req_wdata_q;
  end

  // Control FSM with registered outputs, line metadata and counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      req_write_q     <= 1'b0;
      req_byte_q      <= 1'b0;
      req_addr_q      <= '0;
      req_wdata_q     <= '0;
      missed_q        <= 1'b0;
      victim_q        <= '0;
      req_ready_q     <= 1'b1;
      resp_valid_q    <= 1'b0;
      resp_hit_q      <= 1'b0;
      resp_rdata_q    <= '0;
      mem_req_valid_q <= 1'b0;
      mem_req_write_q <= 1'b0;
      mem_addr_q      <= '0;
      mem_wdata_q     <= '0;
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
          age_q[s][w] <= WAY_W'(w);
        end
      end
`ifdef CACHE_PERF_COUNTERS_EN
      hit_count_q  <= 32'd0;
      miss_count_q <= 32'd0;
      wb_count_q   <= 32'd0;
`endif
    end else begin
      resp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid && req_ready_q) begin
            req_write_q <= req_write;
            req_byte_q  <= req_byte;
            req_addr_q  <= req_addr;
            req_wdata_q <= req_wdata;
            missed_q    <= 1'b0;
            req_ready_q <= 1'b0;
            state_q     <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit_d) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
              age_q[set_d][w] <= new_age_d[w];
            end
            if (req_write_q) begin
              dirty_q[set_d][hit_way_d] <= 1'b1;
            end
            resp_rdata_q <= load_d;
            state_q      <= RESPOND;
          end else begin
            missed_q <= 1'b1;
            victim_q <= victim_d;
            state_q  <= (valid_q[set_d][victim_d] && dirty_q[set_d][victim_d]) ? WRITEBACK : REFILL;
          end
        end
        // Request rises one cycle after entry and then holds until acked.
        WRITEBACK: begin
          if (mem_req_valid_q && mem_ack) begin
            dirty_q[set_d][victim_q] <= 1'b0;
            mem_req_valid_q          <= 1'b0;
            state_q                  <= REFILL;
`ifdef CACHE_PERF_COUNTERS_EN
            wb_count_q <= wb_count_q + 32'd1;
`endif
          end else if (!mem_req_valid_q) begin
            mem_req_valid_q <= 1'b1;
            mem_req_write_q <= 1'b1;
            mem_addr_q      <= line_addr(tag_q[set_d][victim_q], set_d);
            mem_wdata_q     <= data_q[set_d][victim_q];
          end
        end
        REFILL: begin
          if (mem_req_valid_q && mem_ack) begin
            valid_q[set_d][victim_q] <= 1'b1;
            dirty_q[set_d][victim_q] <= 1'b0;
            mem_req_valid_q          <= 1'b0;
            state_q                  <= LOOKUP;
          end else if (!mem_req_valid_q) begin
            mem_req_valid_q <= 1'b1;
            mem_req_write_q <= 1'b0;
            mem_addr_q      <= line_addr(req_tag_d, set_d);
          end
        end
        RESPOND: begin
          resp_valid_q <= 1'b1;
          resp_hit_q   <= ~missed_q;
          req_ready_q  <= 1'b1;
          state_q      <= IDLE;
`ifdef CACHE_PERF_COUNTERS_EN
          if (missed_q) begin
            miss_count_q <= miss_count_q + 32'd1;
          end else begin
            hit_count_q <= hit_count_q + 32'd1;
          end
`endif
        end
        default: begin
          req_ready_q <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  // Line data and tags: store hits and refills; validity is tracked separately.
  always_ff @(posedge clk) begin
    if (state_q == LOOKUP && hit_d && req_write_q) begin
      data_q[set_d][hit_way_d][word_base_d +: WORD_WIDTH] <= store_word_d;
    end else if (state_q == REFILL && mem_req_valid_q && mem_ack) begin
      data_q[set_d][victim_q] <= mem_rdata;
      tag_q[set_d][victim_q]  <= req_tag_d;
    end
  end

  assign req_ready     = req_ready_q;
  assign resp_valid    = resp_valid_q;
  assign resp_rdata    = resp_rdata_q;
  assign resp_hit      = resp_hit_q;
  assign mem_req_valid = mem_req_valid_q;
  assign mem_req_write = mem_req_write_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
`ifdef CACHE_PERF_COUNTERS_EN
  assign hit_count     = hit_count_q;
  assign miss_count    = miss_count_q;
  assign wb_count      = wb_count_q;
`endif

endmodule
